// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder
// Description : Fixed-latency responder for 64-bit line reads and writes from
//               the cache miss/evict FSM. Handles one request at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int LINE_W  = 64,
    parameter int DEPTH_W = 14,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rd_data,
    output logic              rdy,
    output logic              busy
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_wait    = 2'd1;
    localparam logic [1:0] c_st_recover = 2'd2;
    localparam logic [3:0] c_cnt_init   = 4'(LATENCY - 1);

    logic [LINE_W-1:0]  r_mem [0:(1<<DEPTH_W)-1];
    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic [DEPTH_W-1:0] r_addr;
    logic [LINE_W-1:0]  r_wdata;
    logic               r_op_wr;
    logic               r_rdy;
    logic               r_busy;
    logic [LINE_W-1:0]  r_rd_data;
    logic               w_complete;

    assign w_complete = (r_state == c_st_wait) && (r_cnt == 4'd0);

    // Array is not reset; the write is gated by the FSM, so a reset during
    // WAIT drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_complete && r_op_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_op_wr   <= 1'b0;
            r_rdy     <= 1'b0;
            r_busy    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_rdy <= 1'b0;
                    if (re || we) begin
                        r_addr  <= addr[DEPTH_W-1:0];
                        r_wdata <= wdata;
                        r_op_wr <= we;
                        r_cnt   <= c_cnt_init;
                        r_busy  <= 1'b1;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdy   <= 1'b1;
                        r_state <= c_st_recover;
                        if (!r_op_wr) begin
                            r_rd_data <= r_mem[r_addr];
                        end
                    end
                end
                c_st_recover: begin
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign rdy     = r_rdy;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Randomized self-checking bench with a transaction-level model
//               of line_mem_responder (default, LATENCY=1 and LATENCY=15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [13:0] addr0, addr1, addr2;
    logic        re0, re1, re2, we0, we1, we2;
    logic [63:0] wdata0, wdata1, wdata2;
    logic [63:0] rd0, rd1, rd2;
    logic        rdy0, rdy1, rdy2, busy0, busy1, busy2;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mem_m [int];
    logic [63:0] last_rd;

    line_mem_responder dut (
        .clk(clk), .rst(rst), .addr(addr0), .re(re0), .we(we0), .wdata(wdata0),
        .rd_data(rd0), .rdy(rdy0), .busy(busy0)
    );

    line_mem_responder #(.DEPTH_W(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .addr(addr1), .re(re1), .we(we1), .wdata(wdata1),
        .rd_data(rd1), .rdy(rdy1), .busy(busy1)
    );

    line_mem_responder #(.DEPTH_W(8), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst), .addr(addr2), .re(re2), .we(we2), .wdata(wdata2),
        .rd_data(rd2), .rdy(rdy2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int which, input bit r, input bit w,
                         input logic [13:0] a, input logic [63:0] d);
        case (which)
            1:       begin re1 = r; we1 = w; addr1 = a; wdata1 = d; end
            2:       begin re2 = r; we2 = w; addr2 = a; wdata2 = d; end
            default: begin re0 = r; we0 = w; addr0 = a; wdata0 = d; end
        endcase
    endtask

    task automatic obs(input int which, output logic o_rdy, output logic o_busy,
                       output logic [63:0] o_rd);
        case (which)
            1:       begin o_rdy = rdy1; o_busy = busy1; o_rd = rd1; end
            2:       begin o_rdy = rdy2; o_busy = busy2; o_rd = rd2; end
            default: begin o_rdy = rdy0; o_busy = busy0; o_rd = rd0; end
        endcase
    endtask

    // Called 1ns after an edge with the DUT idle. Returns rd_data seen with
    // rdy and the number of edges from acceptance to rdy (-1 on timeout).
    // Finishes 1ns after the edge following rdy (DUT back in IDLE).
    task automatic do_req(input int which, input bit r, input bit w, input bit hold,
                          input logic [13:0] a, input logic [63:0] d,
                          output logic [63:0] got, output int lat);
        logic        v_rdy, v_busy;
        logic [63:0] v_rd;
        got = '0;
        lat = -1;
        drive(which, r, w, a, d);
        @(posedge clk); #1;
        if (!hold) drive(which, 1'b0, 1'b0, 14'($urandom), {$urandom, $urandom});
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            obs(which, v_rdy, v_busy, v_rd);
            if (v_rdy) begin
                lat = k;
                got = v_rd;
                break;
            end
        end
        drive(which, 1'b0, 1'b0, '0, '0);
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [63:0] d, got;
        int          lat;
        checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b0 || rd0 !== 64'h0) begin
            errors++; $display("FAIL reset_initial: rdy=%b busy=%b rd=%h required 0/0/0", rdy0, busy0, rd0);
        end
        rst = 1'b0;
        d = {$urandom, $urandom} | 64'h1;
        do_req(0, 1'b0, 1'b1, 1'b0, 14'h0033, d, got, lat);
        mem_m[14'h0033] = d;
        do_req(0, 1'b1, 1'b0, 1'b0, 14'h0033, 64'h0, got, lat);
        checks++; if (got !== d) begin
            errors++; $display("FAIL reset_preread: rd=%h required %h", got, d);
        end
        drive(0, 1'b1, 1'b0, 14'h0033, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b0 || rd0 !== 64'h0) begin
            errors++; $display("FAIL reset_async: rdy=%b busy=%b rd=%h required 0/0/0", rdy0, busy0, rd0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL reset_held: busy=%b rdy=%b required 0/0", busy0, rdy0);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b rdy=%b required 0/0", busy0, rdy0);
        end
    endtask

    task automatic test_read_latency();
        logic [63:0] d, got;
        int          lat;
        d = 64'h0004_0003_0002_0001;
        do_req(0, 1'b0, 1'b1, 1'b0, 14'h0010, d, got, lat);
        mem_m[14'h0010] = d;
        drive(0, 1'b1, 1'b0, 14'h0010, 64'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 14'h0011, 64'hFFFF);
        checks++; if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL lat_accept: busy=%b rdy=%b required 1/0", busy0, rdy0);
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk); #1;
            checks++; if (rdy0 !== (k == LAT) || busy0 !== (k <= LAT)) begin
                errors++; $display("FAIL lat_cycle%0d: rdy=%b busy=%b required %b/%b",
                                   k, rdy0, busy0, k == LAT, k <= LAT);
            end
            if (k == LAT) begin
                checks++; if (rd0 !== d) begin
                    errors++; $display("FAIL lat_data: rd=%h required %h", rd0, d);
                end
            end
        end
        last_rd = d;
    endtask

    task automatic test_write_read();
        logic [63:0] d, got;
        int          lat;
        d = 64'hDEAD_BEEF_CAFE_F00D;
        do_req(0, 1'b0, 1'b1, 1'b1, 14'h2A05, d, got, lat);
        mem_m[14'h2A05] = d;
        checks++; if (lat != LAT || got !== last_rd) begin
            errors++; $display("FAIL wr_rdy: lat=%0d rd=%h required %0d/%h", lat, got, LAT, last_rd);
        end
        do_req(0, 1'b1, 1'b0, 1'b1, 14'h2A05, 64'h0, got, lat);
        checks++; if (lat != LAT || got !== d) begin
            errors++; $display("FAIL raw_read: lat=%0d rd=%h required %0d/%h", lat, got, LAT, d);
        end
        last_rd = d;
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, d1, d2;
        int          lat;
        int          tq[$];
        logic [63:0] dq[$];
        bit          idle;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        do_req(0, 1'b0, 1'b1, 1'b0, 14'h0001, d1, got, lat);
        do_req(0, 1'b0, 1'b1, 1'b0, 14'h0002, d2, got, lat);
        mem_m[14'h0001] = d1;
        mem_m[14'h0002] = d2;
        drive(0, 1'b1, 1'b0, 14'h0001, 64'h0);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 2) addr0 = 14'h0002;
            if (rdy0) begin
                tq.push_back(i);
                dq.push_back(rd0);
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        checks++; if (tq.size() != 2) begin
            errors++; $display("FAIL b2b_count: pulses=%0d required 2", tq.size());
        end else begin
            checks++; if (tq[0] != LAT + 1 || tq[1] - tq[0] != LAT + 2) begin
                errors++; $display("FAIL b2b_timing: first=%0d spacing=%0d required %0d/%0d",
                                   tq[0], tq[1] - tq[0], LAT + 1, LAT + 2);
            end
            checks++; if (dq[0] !== mem_m[1] || dq[1] !== mem_m[2]) begin
                errors++; $display("FAIL b2b_data: %h %h required %h %h", dq[0], dq[1], mem_m[1], mem_m[2]);
            end
        end
        idle = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(posedge clk); #1;
            if (!busy0 && !rdy0) idle = 1'b1;
        end
        checks++; if (!idle) begin
            errors++; $display("FAIL b2b_drain: busy=%b required 0", busy0);
        end
        last_rd = mem_m[2];
    endtask

    task automatic test_collision_abort();
        logic [63:0] got;
        int          lat;
        do_req(0, 1'b1, 1'b1, 1'b0, 14'h0100, 64'h1, got, lat);
        mem_m[14'h0100] = 64'h1;
        checks++; if (lat != LAT || got !== last_rd) begin
            errors++; $display("FAIL coll_rdy: lat=%0d rd=%h required %0d/%h", lat, got, LAT, last_rd);
        end
        do_req(0, 1'b1, 1'b0, 1'b0, 14'h0100, 64'h0, got, lat);
        checks++; if (got !== 64'h1) begin
            errors++; $display("FAIL coll_read: rd=%h required %h", got, 64'h1);
        end
        drive(0, 1'b0, 1'b1, 14'h0100, 64'h2);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (rd0 !== 64'h0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL abort_reset: rd=%h busy=%b required 0/0", rd0, busy0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = '0;
        do_req(0, 1'b1, 1'b0, 1'b0, 14'h0100, 64'h0, got, lat);
        checks++; if (lat != LAT || got !== mem_m[14'h0100]) begin
            errors++; $display("FAIL abort_read: lat=%0d rd=%h required %0d/%h", lat, got, LAT, mem_m[14'h0100]);
        end
        last_rd = got;
    endtask

    task automatic test_random();
        logic [13:0] pool [8];
        logic [63:0] got, d;
        logic [13:0] a;
        int          lat;
        bit          wr;
        for (int i = 0; i < 8; i++) pool[i] = 14'($urandom);
        for (int n = 0; n < 24; n++) begin
            a  = pool[$urandom_range(0, 7)];
            wr = (n < 4) || ($urandom_range(0, 1) == 1) || !mem_m.exists(int'(a));
            d  = {$urandom, $urandom};
            do_req(0, !wr || ($urandom_range(0, 3) == 0), wr, 1'($urandom_range(0, 1)), a, d, got, lat);
            if (wr) begin
                mem_m[int'(a)] = d;
                checks++; if (lat != LAT || got !== last_rd) begin
                    errors++; $display("FAIL rand_wr%0d: lat=%0d rd=%h required %0d/%h", n, lat, got, LAT, last_rd);
                end
            end else begin
                checks++; if (lat != LAT || got !== mem_m[int'(a)]) begin
                    errors++; $display("FAIL rand_rd%0d: lat=%0d rd=%h required %0d/%h",
                                       n, lat, got, LAT, mem_m[int'(a)]);
                end
                last_rd = mem_m[int'(a)];
            end
        end
    endtask

    task automatic test_param_sweep();
        logic [63:0] d, got;
        int          lat;
        d = {$urandom, $urandom};
        do_req(1, 1'b0, 1'b1, 1'b0, 14'h0105, d, got, lat);
        checks++; if (lat != 1) begin
            errors++; $display("FAIL l1_wr_lat: lat=%0d required 1", lat);
        end
        do_req(1, 1'b1, 1'b0, 1'b0, 14'h0005, 64'h0, got, lat);
        checks++; if (lat != 1 || got !== d) begin
            errors++; $display("FAIL l1_alias: lat=%0d rd=%h required 1/%h", lat, got, d);
        end
        d = {$urandom, $urandom};
        do_req(2, 1'b0, 1'b1, 1'b1, 14'h0005, d, got, lat);
        checks++; if (lat != 15) begin
            errors++; $display("FAIL l15_wr_lat: lat=%0d required 15", lat);
        end
        do_req(2, 1'b1, 1'b0, 1'b0, 14'h0105, 64'h0, got, lat);
        checks++; if (lat != 15 || got !== d) begin
            errors++; $display("FAIL l15_alias: lat=%0d rd=%h required 15/%h", lat, got, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        last_rd = '0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_read_latency();
        test_write_read();
        test_back_to_back();
        test_collision_abort();
        test_random();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
